// File: rtl/imm_pkg.sv
// Shared types and the immediate-extension function for the decode-stage immediate generator.
package imm_pkg;

    localparam int unsigned MAX_XLEN  = 64;
    localparam int unsigned MAX_TAG_W = 64;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_ILL = 3'd7
    } imm_src_e;

    typedef struct packed {
        logic [MAX_TAG_W-1:0] tag;
        logic                 err;
        logic [MAX_XLEN-1:0]  imm;
    } imm_entry_t;

    // base_imm[k] is instr[k+7]; result is always 64 bits and truncated by the caller.
    function automatic logic [63:0] imm_extend(input logic [24:0] base_imm,
                                               input logic [2:0]  imm_src);
        logic [63:0] r;
        case (imm_src_e'(imm_src))
            IMM_I:   r = {{52{base_imm[24]}}, base_imm[24:13]};
            IMM_S:   r = {{52{base_imm[24]}}, base_imm[24:18], base_imm[4:0]};
            IMM_B:   r = {{51{base_imm[24]}}, base_imm[24], base_imm[0], base_imm[23:18],
                          base_imm[4:1], 1'b0};
            IMM_J:   r = {{43{base_imm[24]}}, base_imm[24], base_imm[12:5], base_imm[13],
                          base_imm[23:14], 1'b0};
            IMM_U:   r = {{32{base_imm[24]}}, base_imm[24:5], 12'b0};
            IMM_Z:   r = {59'b0, base_imm[12:8]};
            IMM_SH:  r = {58'b0, base_imm[18:13]};
            default: r = 64'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry FIFO-ordered valid/ready skid buffer with synchronous flush and registered ready.
module skid_buf2 #(
    parameter int unsigned DataW = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DataW-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DataW-1:0] o_data
);

    logic [DataW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [1:0]       r_count, w_count_nxt;
    logic             r_in_ready, w_in_ready_nxt;
    logic             w_in_fire, w_out_fire;

    assign w_in_fire  = i_valid && r_in_ready;
    assign w_out_fire = (r_count != 2'd0) && i_ready;

    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_in_fire) begin
                        w_head_nxt  = i_data;
                        w_count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    if (w_in_fire && w_out_fire) begin
                        w_head_nxt = i_data;
                    end else if (w_in_fire) begin
                        w_tail_nxt  = i_data;
                        w_count_nxt = 2'd2;
                    end else if (w_out_fire) begin
                        w_count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    // Ready was low, so only a drain can happen here.
                    if (w_out_fire) begin
                        w_head_nxt  = r_tail;
                        w_count_nxt = 2'd1;
                    end
                end
                default: w_count_nxt = 2'd0;
            endcase
        end
        w_in_ready_nxt = (w_count_nxt != 2'd2);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational extension feeding a 2-entry skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      base_imm,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned PayloadW = TAG_W + 1 + XLEN;

    logic [63:0]         w_ext;
    logic [XLEN-1:0]     w_imm;
    logic                w_err;
    logic [PayloadW-1:0] w_in_data, w_out_data;

    assign w_ext = imm_extend(base_imm, imm_src);
    assign w_err = (imm_src == IMM_ILL);

    // RV32 shift amounts are only 5 bits wide.
    always_comb begin
        w_imm = w_ext[XLEN-1:0];
        if (XLEN == 32 && imm_src == IMM_SH) begin
            w_imm[5] = 1'b0;
        end
    end

    if (XLEN < 64) begin : g_trunc
        logic w_unused_hi;
        assign w_unused_hi = ^w_ext[63:XLEN];
    end

    assign w_in_data = {in_tag, w_err, w_imm};

    skid_buf2 #(
        .DataW(PayloadW)
    ) u_skid (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_flush(flush),
        .i_valid(in_valid),
        .o_ready(in_ready),
        .i_data (w_in_data),
        .o_valid(out_valid),
        .i_ready(out_ready),
        .o_data (w_out_data)
    );

    assign {out_tag, out_err, out_imm} = w_out_data;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and scoreboarded checks for imm_gen_pipe at XLEN=32.
module tb_imm_gen_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      base_imm;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] tag;
        logic        err;
        logic [31:0] imm;
    } ent_t;

    vec_t        vecs[8];
    ent_t        q[$];
    ent_t        e;
    logic [31:0] held_imm;
    logic [31:0] instr;
    logic [2:0]  s;
    logic        v, r, f, m_in, m_out;

    imm_gen_pipe #(
        .XLEN (XLEN),
        .TAG_W(TAG_W)
    ) dut (
        .clock    (clk),
        .reset    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .base_imm (base_imm),
        .imm_src  (imm_src),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm  (out_imm),
        .out_tag  (out_tag),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [24:0] b, input logic [2:0] src, input logic [31:0] t);
        in_valid = 1'b1;
        base_imm = b;
        imm_src  = src;
        in_tag   = t;
    endtask

    // Reference written from the full instruction word view.
    function automatic ent_t ref_ent(input logic [31:0] i, input logic [2:0] src,
                                     input logic [31:0] t);
        ent_t x;
        x.tag = t;
        x.err = (src == 3'd7);
        case (src)
            3'd0:    x.imm = {{20{i[31]}}, i[31:20]};
            3'd1:    x.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    x.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    x.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    x.imm = {i[31:12], 12'b0};
            3'd5:    x.imm = {27'b0, i[19:15]};
            3'd6:    x.imm = {27'b0, i[24:20]};
            default: x.imm = 32'b0;
        endcase
        return x;
    endfunction

    initial begin
        vecs[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0};
        vecs[1] = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 1'b0};
        vecs[2] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0};
        vecs[3] = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 1'b0};
        vecs[4] = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0};
        vecs[5] = '{32'h000F8000, 3'd5, 32'h0000001F, 1'b0};
        vecs[6] = '{32'h03F00000, 3'd6, 32'h0000001F, 1'b0};
        vecs[7] = '{32'hFFFFFF80, 3'd7, 32'h00000000, 1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        base_imm  = '0;
        imm_src   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back formats with out_ready high: one entry per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].instr[31:7], vecs[k].src, 32'h100 + k);
            step();
            check($sformatf("fmt%0d_valid", k), out_valid, 1);
            check($sformatf("fmt%0d_imm", k), out_imm, vecs[k].exp);
            check($sformatf("fmt%0d_err", k), out_err, vecs[k].err);
            check($sformatf("fmt%0d_tag", k), out_tag, 32'h100 + k);
            check($sformatf("fmt%0d_ready", k), in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);

        // Backpressure: three entries offered while stalled.
        out_ready = 1'b0;
        drive(vecs[0].instr[31:7], 3'd0, 32'd1);
        step();
        check("bp1_ready", in_ready, 1);
        held_imm = out_imm;
        drive(vecs[2].instr[31:7], 3'd2, 32'd2);
        step();
        check("bp2_ready", in_ready, 0);
        check("bp2_head_tag", out_tag, 1);
        drive(vecs[4].instr[31:7], 3'd4, 32'd3);
        step();
        check("bp3_ready", in_ready, 0);
        check("bp3_stable_tag", out_tag, 1);
        check("bp3_stable_imm", out_imm, held_imm);
        check("bp3_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("rel1_tag", out_tag, 2);
        check("rel1_imm", out_imm, 32'hFFFFFFFC);
        check("rel1_ready", in_ready, 1);
        step();
        check("rel2_tag", out_tag, 3);
        check("rel2_imm", out_imm, 32'h80000000);
        in_valid = 1'b0;
        step();
        check("rel3_valid", out_valid, 0);

        // Flush with two entries held and a concurrent input.
        out_ready = 1'b0;
        drive(vecs[0].instr[31:7], 3'd0, 32'd10);
        step();
        drive(vecs[1].instr[31:7], 3'd1, 32'd11);
        step();
        check("fl_full_ready", in_ready, 0);
        drive(vecs[2].instr[31:7], 3'd2, 32'd12);
        flush = 1'b1;
        step();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_none_valid", out_valid, 0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(vecs[3].instr[31:7], 3'd3, 32'd20);
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_tag", out_tag, 0);
        check("ar_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Random stream against the scoreboard.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            check("rnd_valid", out_valid, q.size() != 0);
            check("rnd_ready", in_ready, q.size() < 2);
            if (q.size() != 0) begin
                check("rnd_imm", out_imm, q[0].imm);
                check("rnd_tag", out_tag, q[0].tag);
                check("rnd_err", out_err, q[0].err);
            end
            instr = $urandom;
            s     = 3'($urandom_range(0, 7));
            v     = ($urandom_range(0, 9) < 7);
            r     = ($urandom_range(0, 9) < 6);
            f     = ($urandom_range(0, 99) == 0);
            drive(instr[31:7], s, c);
            in_valid  = v;
            out_ready = r;
            flush     = f;
            m_in  = v && (q.size() < 2);
            m_out = r && (q.size() != 0);
            if (f) begin
                q.delete();
            end else begin
                if (m_out) begin
                    e = q.pop_front();
                end
                if (m_in) begin
                    q.push_back(ref_ent(instr, s, c));
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. Accepts `base_imm` (instruction bits [31:7]) plus an immediate-format select under a valid/ready handshake. It produces the extended immediate for all RV32I/RV64I formats, plus CSR zimm and shift-amount. Output is registered through a 2-entry skid buffer, giving full throughput under backpressure and a pipeline flush.

## Interface
- `XLEN`, default 32: output immediate width; legal values 32, 64.
- `TAG_W`, default 32: width of the sideband tag (PC, rd, etc.) carried alongside each immediate.
- `clock` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; drops all buffered and incoming entries.
- `in_valid` input 1: input entry valid.
- `in_ready` output 1: block can accept an entry this cycle.
- `base_imm` input 25: instruction bits [31:7]; `base_imm[k]` = `instr[k+7]`.
- `imm_src` input 3: format select, `imm_src_e` encoding.
- `in_tag` input TAG_W: passed through unchanged.
- `out_valid` output 1: output entry valid.
- `out_ready` input 1: consumer accepts the output entry.
- `out_imm` output XLEN: extended immediate.
- `out_tag` output TAG_W: tag of the output entry.
- `out_err` output 1: the entry had an illegal `imm_src`.

## Operation
Formats use `b` = `base_imm`. "sext" means replicate `b[24]` up to XLEN.
- 000 I: sext(`b[24:13]`).
- 001 S: sext({`b[24:18]`, `b[4:0]`}).
- 010 B: sext({`b[24]`, `b[0]`, `b[23:18]`, `b[4:1]`, 1'b0}).
- 011 J: sext({`b[24]`, `b[12:5]`, `b[13]`, `b[23:14]`, 1'b0}).
- 100 U: sext({`b[24:5]`, 12'b0}). When XLEN=64, bits [63:32] equal `b[24]`.
- 101 Z (CSR zimm): zero-extend `b[12:8]`.
- 110 SH (shamt): zero-extend `b[18:13]` when XLEN=64; zero-extend `b[17:13]` when XLEN=32.
- 111 illegal: `out_imm` = 0, `out_err` = 1.

Handshake and buffering:
- The extension logic is combinational on the input. Its result is written into the skid buffer on input fire (`in_valid && in_ready`).
- Output fire is `out_valid && out_ready`.
- The buffer holds 0, 1 or 2 entries and is FIFO-ordered. `out_*` always present the head entry.
- `in_ready` = 1 when fewer than 2 entries are held. It is registered and does not depend combinationally on `out_ready`.
- Simultaneous input fire and output fire at occupancy 1: the count stays 1 and the new entry becomes the head.
- At occupancy 2, input is not accepted, even if the output fires that cycle.
- `out_*` must stay stable while `out_valid && !out_ready`.

Flush:
- `flush` empties the buffer at the next edge.
- An input that fires in the same cycle as `flush` is discarded.
- Flush takes priority over all other events.

## Timing
- Latency: an entry accepted at edge N is visible on `out_*` after edge N, provided the buffer was empty or the head fired at edge N.
- Throughput: one entry per cycle while `out_ready` = 1.
- Reset (asynchronous assert): `out_valid` = 0, `in_ready` = 1, `out_imm` = 0, `out_tag` = 0, `out_err` = 0, occupancy = 0.
- Reset mid-stream discards all buffered entries.
- Deassertion of `reset` is synchronised externally.
- After `flush`: `out_valid` = 0 and `in_ready` = 1 on the following cycle.

## Structure
- Package `imm_pkg`:
  - `imm_src_e` enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_ILL).
  - `imm_entry_t` packed struct parameterised by the largest supported widths.
  - Function `imm_extend(base_imm, imm_src)` returning a 64-bit value; the top level truncates it to XLEN.
- Sub-module `skid_buf2`: generic 2-entry valid/ready skid buffer with flush, parameterised on payload width. The top level is the extension function plus a `skid_buf2` instance.

## Test plan
- Reset and I-format: `base_imm` = 0x1FFE001 (from 0xFFF00093), I, `out_ready` = 1 → after one edge, `out_imm` = 0xFFFFFFFF, `out_valid` = 1, `out_err` = 0.
- B and U formats:
  - 0xFE000EE3 >> 7, B → `out_imm` = 0xFFFFFFFC.
  - 0x800000B7 >> 7, U → 0x80000000 when XLEN=32, 0xFFFFFFFF80000000 when XLEN=64.
- Backpressure: hold `out_ready` = 0 and send 3 back-to-back entries with tags 1, 2, 3 → `in_ready` drops after 2 accepted. Release `out_ready` → tags emerge 1, 2, 3 with no loss and no duplication, and `out_*` stay stable while stalled.
- Flush: with 2 entries held, assert `flush` together with `in_valid` → `out_valid` = 0 next cycle, `in_ready` = 1, no entry emitted.
- Zero-extended and illegal formats:
  - Z with `b[12:8]` = 0x1F → 0x1F.
  - SH with `b[18:13]` = 0x3F → 0x3F when XLEN=64, 0x1F when XLEN=32.
  - `imm_src` = 7 → `out_imm` = 0, `out_err` = 1.
- Random stream: random formats, `base_imm`, `in_valid`, `out_ready` and rare `flush`, checked against a scoreboard reference model over 10k cycles.
